// File: rtl/pap_pkg.sv
// pap_pkg: shared op encodings, FSM states and iteration count for the multiply/divide unit.
package pap_pkg;
    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;
    localparam int ITER = 32;
    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;
endpackage

// File: rtl/mdu_sign_fix.sv
// mdu_sign_fix: conditional two's-complement negate, used both for operand magnitudes and result signs.
module mdu_sign_fix #(
    parameter int W = 64
) (
    input  logic [W-1:0] x,
    input  logic         neg,
    output logic [W-1:0] y
);
    assign y = neg ? -x : x;
endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative radix-2 MULT/MULTU/DIV/DIVU on unsigned magnitudes, signs restored at the end.
module mult_div_unit import pap_pkg::*; #(
    parameter int ITER = pap_pkg::ITER
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        we_hi,
    input  logic        we_lo,
    input  logic [31:0] wd,
    output logic        busy,
    output logic        done,
    output logic        div_by_zero,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    state_t state, state_nx;
    logic [5:0]  cnt;
    logic [63:0] acc, prod;
    logic [31:0] bm, a_abs, b_abs, quo, rem;
    logic [32:0] add_s, sub_s;
    logic        a_neg, b_neg, div_r, dz, is_signed, accept;

    assign is_signed = op == OP_MULT || op == OP_DIV;
    assign accept    = state == IDLE && start;
    assign add_s     = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, bm} : 33'd0);
    assign sub_s     = acc[63:31] - {1'b0, bm};

    mdu_sign_fix #(.W(32)) u_abs_a (.x(a), .neg(is_signed & a[31]), .y(a_abs));
    mdu_sign_fix #(.W(32)) u_abs_b (.x(b), .neg(is_signed & b[31]), .y(b_abs));
    mdu_sign_fix #(.W(64)) u_prod  (.x(acc), .neg(a_neg ^ b_neg), .y(prod));
    mdu_sign_fix #(.W(32)) u_quo   (.x(acc[31:0]), .neg(a_neg ^ b_neg), .y(quo));
    // remainder takes the dividend's sign; with b==0 it is |a| and so restores a exactly
    mdu_sign_fix #(.W(32)) u_rem   (.x(acc[63:32]), .neg(a_neg), .y(rem));

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;

    always_comb
        state_nx = state == IDLE ? (start ? RUN : IDLE) :
                   state == RUN  ? (cnt == 6'(ITER - 1) ? FINISH : RUN) : IDLE;

    always_comb
        busy = state != IDLE;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            cnt         <= '0;
            acc         <= '0;
            bm          <= '0;
            a_neg       <= 1'b0;
            b_neg       <= 1'b0;
            div_r       <= 1'b0;
            dz          <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            hi          <= '0;
            lo          <= '0;
        end else begin
            if (accept) begin
                acc   <= {32'd0, a_abs};
                bm    <= b_abs;
                a_neg <= is_signed & a[31];
                b_neg <= is_signed & b[31];
                div_r <= op[1];
                dz    <= op[1] && b == '0;
            end else if (state == RUN)
                acc <= div_r ? (sub_s[32] ? {acc[62:0], 1'b0} : {sub_s[31:0], acc[30:0], 1'b1})
                             : {add_s, acc[31:1]};
            cnt         <= (state == RUN && cnt != 6'(ITER - 1)) ? cnt + 6'd1 : 6'd0;
            done        <= state == FINISH;
            div_by_zero <= state == FINISH && dz;
            if (state == FINISH) begin
                hi <= div_r ? rem : prod[63:32];
                lo <= div_r ? (dz ? '1 : quo) : prod[31:0];
            end else if (state == IDLE) begin
                if (we_hi) hi <= wd;
                if (we_lo) lo <= wd;
            end
        end
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: vector table plus random ops through a scoreboard, and hand-written corner sequences.
module tb_mult_div_unit;
    import pap_pkg::*;

    logic clk, rst_n, start, we_hi, we_lo;
    logic [1:0]  op;
    logic [31:0] a, b, wd, hi, lo;
    logic busy, done, div_by_zero;

    typedef struct {logic [31:0] hi, lo; logic dz;} exp_t;
    typedef struct {logic [1:0] op; logic [31:0] a, b; exp_t e;} vec_t;

    exp_t sbq[$];
    vec_t tbl[13];
    int   nerr = 0, nchk = 0;

    mult_div_unit dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .we_hi(we_hi), .we_lo(we_lo), .wd(wd), .busy(busy), .done(done),
        .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        exp_t r;
        logic [63:0] p;
        int sx, sy;
        r.dz = 1'b0;
        sx = x;
        sy = y;
        if (!o[1]) begin
            p = o == OP_MULT ? {{32{x[31]}}, x} * {{32{y[31]}}, y} : {32'd0, x} * {32'd0, y};
            r.hi = p[63:32];
            r.lo = p[31:0];
        end else if (y == 0) begin
            r.hi = x; r.lo = '1; r.dz = 1'b1;
        end else if (o == OP_DIVU) begin
            r.lo = x / y; r.hi = x % y;
        end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
            r.lo = x; r.hi = 0;
        end else begin
            r.lo = sx / sy; r.hi = sx % sy;
        end
        return r;
    endfunction

    task automatic wait_done(input string nm, input exp_t e, input int inj);
        logic [31:0] h0, l0;
        int n;
        bit stable, busy_ok;
        exp_t x;
        sbq.push_back(e);
        chk({nm, " busy_on"}, busy, 1);
        h0 = hi; l0 = lo; stable = 1; busy_ok = 1; n = 0;
        while (n < 40) begin
            if (n == inj) begin
                start = 1; we_lo = 1; wd = 32'h5555_AAAA; op = OP_DIVU; a = 1; b = 1;
            end
            tick();
            n++;
            start = 0; we_lo = 0;
            if (done) break;
            if (hi !== h0 || lo !== l0) stable = 0;
            if (!busy) busy_ok = 0;
        end
        x = sbq.pop_front();
        chk({nm, " latency"}, n, 33);
        chk({nm, " hilo_stable"}, stable, 1);
        chk({nm, " busy_held"}, busy_ok, 1);
        chk({nm, " busy_off"}, busy, 0);
        chk({nm, " hi"}, hi, x.hi);
        chk({nm, " lo"}, lo, x.lo);
        chk({nm, " dz"}, div_by_zero, x.dz);
        tick();
        chk({nm, " done_1cyc"}, done, 0);
        chk({nm, " dz_1cyc"}, div_by_zero, 0);
    endtask

    task automatic run_op(input string nm, input logic [1:0] o, input logic [31:0] x,
                          input logic [31:0] y, input exp_t e, input int inj);
        op = o; a = x; b = y; start = 1;
        tick();
        start = 0;
        wait_done(nm, e, inj);
    endtask

    initial begin
        tbl[0]  = '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, '{32'hFFFF_FFFE, 32'h0000_0001, 1'b0}};
        tbl[1]  = '{OP_MULT,  32'hFFFF_FFFD, 32'd7,         '{32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0}};
        tbl[2]  = '{OP_DIV,   32'hFFFF_FFF9, 32'd2,         '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0}};
        tbl[3]  = '{OP_DIVU,  32'd100,       32'd7,         '{32'd2,         32'd14,        1'b0}};
        tbl[4]  = '{OP_DIVU,  32'd5,         32'd0,         '{32'd5,         32'hFFFF_FFFF, 1'b1}};
        tbl[5]  = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, '{32'd0,         32'h8000_0000, 1'b0}};
        tbl[6]  = '{OP_DIV,   32'hFFFF_FFF9, 32'd0,         '{32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1}};
        tbl[7]  = '{OP_MULT,  32'h8000_0000, 32'h8000_0000, '{32'h4000_0000, 32'd0,         1'b0}};
        tbl[8]  = '{OP_DIV,   32'd7,         32'hFFFF_FFFE, '{32'd1,         32'hFFFF_FFFD, 1'b0}};
        tbl[9]  = '{OP_MULTU, 32'h1234_5678, 32'd0,         '{32'd0,         32'd0,         1'b0}};
        tbl[10] = '{OP_MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, '{32'd0,         32'd1,         1'b0}};
        tbl[11] = '{OP_DIVU,  32'hFFFF_FFFF, 32'd1,         '{32'd0,         32'hFFFF_FFFF, 1'b0}};
        tbl[12] = '{OP_MULT,  32'd5,         32'd0,         '{32'd0,         32'd0,         1'b0}};

        rst_n = 0; start = 0; op = 0; a = 0; b = 0; we_hi = 0; we_lo = 0; wd = 0;
        #12;
        chk("reset hi", hi, 0);
        chk("reset lo", lo, 0);
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset dz", div_by_zero, 0);
        rst_n = 1;
        tick();

        for (int i = 0; i < 13; i++)
            run_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].e, -1);

        for (int i = 0; i < 8; i++) begin
            logic [1:0]  o;
            logic [31:0] x, y;
            o = 2'($urandom_range(3));
            x = $urandom;
            y = i[0] ? 32'($urandom_range(1, 300)) : $urandom;
            run_op($sformatf("rnd%0d", i), o, x, y, model(o, x, y), -1);
        end

        we_hi = 1; wd = 32'h1111_2222;
        tick();
        we_hi = 0;
        chk("mthi", hi, 32'h1111_2222);
        we_lo = 1; wd = 32'h3333_4444;
        tick();
        we_lo = 0;
        chk("mtlo", lo, 32'h3333_4444);
        chk("mtlo keeps hi", hi, 32'h1111_2222);
        we_hi = 1; we_lo = 1; wd = 32'hABCD_0123;
        tick();
        we_hi = 0; we_lo = 0;
        chk("mthilo hi", hi, 32'hABCD_0123);
        chk("mthilo lo", lo, 32'hABCD_0123);

        op = OP_MULTU; a = 6; b = 7; start = 1; we_hi = 1; wd = 32'hDEAD_BEEF;
        tick();
        start = 0; we_hi = 0;
        chk("start+mthi hi", hi, 32'hDEAD_BEEF);
        wait_done("start+mthi", '{32'd0, 32'd42, 1'b0}, -1);

        run_op("ignore", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, '{32'hFFFF_FFFE, 32'h1, 1'b0}, 10);

        we_hi = 1; we_lo = 1; wd = 32'hCAFE_F00D;
        tick();
        we_hi = 0; we_lo = 0;
        op = OP_DIV; a = 32'd1000; b = 32'd3; start = 1;
        tick();
        start = 0;
        repeat (14) tick();
        #2 rst_n = 0;
        #1;
        chk("abort hi", hi, 0);
        chk("abort lo", lo, 0);
        chk("abort busy", busy, 0);
        tick();
        chk("abort done", done, 0);
        chk("abort busy2", busy, 0);
        op = OP_MULTU; a = 3; b = 4; start = 1;
        #2 rst_n = 1;
        tick();
        start = 0;
        wait_done("after_reset", '{32'd0, 32'd12, 1'b0}, -1);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 The block SHALL use one clock and a reset that is asynchronous and active-low.
REQ-002 Port list: clk  in  1  rising-edge clock.
REQ-003 Port list: rst_n  in  1  asynchronous active-low reset.
REQ-004 Port list: start  in  1  request an operation; sampled only in IDLE.
REQ-005 Port list: op  in  2  operation code: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 Port list: a  in  32  operand A (register-file RD1), captured on an accepted start.
REQ-007 Port list: b  in  32  operand B (register-file RD2), captured on an accepted start.
REQ-008 Port list: we_hi, we_lo  in  1 each  MTHI/MTLO write enables.
REQ-009 Port list: wd  in  32  MTHI/MTLO write data.
REQ-010 Port list: busy  out  1  operation in progress.
REQ-011 Port list: done  out  1  one-cycle pulse when HI/LO hold a new result.
REQ-012 Port list: div_by_zero  out  1  pulses with done when a DIV/DIVU had b==0.
REQ-013 Port list: hi, lo  out  32 each  architectural HI/LO registers, driven directly from flops.
REQ-014 Parameter: ITER, default 32, number of iteration cycles; only 32 is supported.

Function
REQ-015 The state machine SHALL have three states: IDLE, RUN, FINISH.
REQ-016 IDLE with start=1 at edge N: capture a, b and op; enter RUN; busy=1 from N+1.
REQ-017 RUN: one radix-2 step per cycle (shift-add multiply, restoring divide); exactly 32 cycles; a 6-bit counter counts 0..31.
REQ-018 After the 32nd step, enter FINISH; at edge N+33 write hi/lo, set done=1, set busy=0, and return to IDLE; done lasts exactly one cycle.
REQ-019 start while busy SHALL be ignored; no queueing.
REQ-020 MULT/MULTU: {hi,lo} SHALL equal the full 64-bit product; MULT is two's-complement (operand magnitudes multiplied, then the product negated if a[31]^b[31]).
REQ-021 DIV/DIVU: lo SHALL be the quotient and hi the remainder; DIV truncates toward zero; the quotient sign is a[31]^b[31]; the remainder sign follows a.
REQ-022 Divide with b==0: takes the same 33-cycle latency; lo=32'hFFFF_FFFF, hi=a; div_by_zero=1 together with done.
REQ-023 DIV 32'h8000_0000 / 32'hFFFF_FFFF SHALL give lo=32'h8000_0000, hi=0, with no flag.
REQ-024 we_hi/we_lo in IDLE SHALL load wd into hi/lo at the next edge; both may be asserted together.
REQ-025 we_hi/we_lo while busy SHALL be ignored.
REQ-026 If start and a write enable are both asserted in IDLE, the write SHALL take effect and the operation SHALL start; the operation result later overwrites hi/lo.
REQ-027 hi/lo SHALL NOT change during RUN; intermediate values stay in internal registers.

Reset
REQ-028 rst_n=0 SHALL immediately force: state=IDLE, busy=0, done=0, div_by_zero=0, hi=0, lo=0, counter=0.
REQ-029 Reset asserted mid-operation SHALL abort the operation with no result written.
REQ-030 After reset release, the first edge SHALL accept start.

Structure
REQ-031 The shared package pap_pkg SHALL hold the op encodings (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU), the state enum and ITER.
REQ-032 One sub-module is natural: mdu_sign_fix, combinational absolute value and conditional 64-bit negate, instantiated for operand and result sign handling.
REQ-033 The width of the datapath beyond 64-bit accumulator plus 32-bit divisor SHALL NOT grow.

Verification
REQ-034 MULTU a=32'hFFFF_FFFF, b=32'hFFFF_FFFF -> done at cycle 33; hi=32'hFFFF_FFFE, lo=32'h0000_0001.
REQ-035 MULT a=-3 (32'hFFFF_FFFD), b=7 -> hi=32'hFFFF_FFFF, lo=32'hFFFF_FFEB.
REQ-036 DIV a=-7, b=2 -> lo=32'hFFFF_FFFD, hi=32'hFFFF_FFFF; DIVU a=100, b=7 -> lo=14, hi=2.
REQ-037 DIVU a=5, b=0 -> lo=32'hFFFF_FFFF, hi=5, div_by_zero=1 for exactly one cycle.
REQ-038 Second start and we_lo asserted at cycle 10 of a running MULTU -> both ignored; the result is unchanged, and busy stays 1 until cycle 33.
REQ-039 rst_n pulsed low at cycle 15 of a DIV -> hi=lo=0, busy=0, no done pulse; a new start accepted after release completes normally.
